// File: rtl/sat_arb_pkg.sv
// Shared constants, types and helpers for the saturating-add arbiter.
package sat_arb_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 4;
    localparam int IDW_DEF   = $clog2(NREQ_DEF);

    // Value driven on res_sum when the addition overflows (default width).
    localparam logic [WIDTH_DEF-1:0] SAT_MAX = '1;

    // Output register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // Requester-ID width. This is clamped to at least 1 bit.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sat_add_arbiter_if.sv
// Requester/result bus between the operand producers, the arbiter and the consumer.
interface sat_add_arbiter_if
    import sat_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
);
    localparam int IDW = id_width(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_sum;
    logic [IDW-1:0]        res_id;
    logic                  res_sat;

    // The arbiter side of the bus.
    modport slave (
        input  req, a_in, b_in, res_ready,
        output gnt, res_valid, res_sum, res_id, res_sat
    );

    // The producer/consumer side of the bus.
    modport master (
        output req, a_in, b_in, res_ready,
        input  gnt, res_valid, res_sum, res_id, res_sat
    );
endinterface

// File: rtl/sat_add_unit.sv
// Combinational WIDTH-bit unsigned adder. It clamps to all ones on carry-out.
module sat_add_unit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             sat
);
    logic [WIDTH:0] ext_sum;

    // Add with one guard bit. The guard bit selects the clamped result.
    always_comb begin
        ext_sum = {1'b0, a} + {1'b0, b};
        sat     = ext_sum[WIDTH];
        sum     = ext_sum[WIDTH] ? {WIDTH{1'b1}} : ext_sum[WIDTH-1:0];
    end
endmodule

// File: rtl/sat_add_arbiter.sv
// Round-robin arbiter in front of one shared saturating adder, with a
// single-entry valid/ready result register.
module sat_add_arbiter
    import sat_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    sat_add_arbiter_if.slave  bus
);
    localparam int IDW = id_width(NREQ);
    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];

    logic [IDW-1:0]   last_reg;
    logic [IDW-1:0]   win_idx;
    logic             win_found;
    logic             accept;
    logic [NREQ-1:0]  gnt_comb;
    logic             transfer;
    logic             load;
    logic [WIDTH-1:0] add_sum;
    logic             add_sat;

    out_state_t       state_reg, state_next;
    logic [WIDTH-1:0] sum_reg;
    logic [IDW-1:0]   id_reg;
    logic             sat_reg;

    // Unpack the per-requester operand lanes.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign a_arr[gi] = bus.a_in[gi*WIDTH +: WIDTH];
        assign b_arr[gi] = bus.b_in[gi*WIDTH +: WIDTH];
    end

    // Search for the first active request, starting one past the last winner.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && bus.req[(int'(last_reg) + 1 + k) % NREQ]) begin
                win_found = 1'b1;
                win_idx   = IDW'((int'(last_reg) + 1 + k) % NREQ);
            end
        end
    end

    // Issue a grant only when the result register can take a new value. The
    // grant is held off while in reset.
    always_comb begin
        accept   = (state_reg == ST_EMPTY) || bus.res_ready;
        gnt_comb = '0;
        if (win_found && accept && rst_n) begin
            gnt_comb = NREQ'(1) << win_idx;
        end
        transfer = |(bus.req & gnt_comb);
    end

    sat_add_unit #(.WIDTH(WIDTH)) u_add (
        .a   (a_arr[win_idx]),
        .b   (b_arr[win_idx]),
        .sum (add_sum),
        .sat (add_sat)
    );

    // Output register next state. It loads on a transfer and drains on ready.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (transfer) begin
                    state_next = ST_FULL;
                    load       = 1'b1;
                end
            end
            ST_FULL: begin
                if (bus.res_ready) begin
                    if (transfer) begin
                        load = 1'b1;
                    end else begin
                        state_next = ST_EMPTY;
                    end
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // State, result payload and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
            sum_reg   <= '0;
            id_reg    <= '0;
            sat_reg   <= 1'b0;
            last_reg  <= LAST_RST;
        end else begin
            state_reg <= state_next;
            if (load) begin
                sum_reg <= add_sum;
                id_reg  <= win_idx;
                sat_reg <= add_sat;
            end
            if (transfer) begin
                last_reg <= win_idx;
            end
        end
    end

    assign bus.gnt       = gnt_comb;
    assign bus.res_valid = (state_reg == ST_FULL);
    assign bus.res_sum   = sum_reg;
    assign bus.res_id    = id_reg;
    assign bus.res_sat   = sat_reg;
endmodule

// File: tb/tb_sat_add_arbiter.sv
// Randomised and directed bench for sat_add_arbiter against a behavioural model.
module tb_sat_add_arbiter;
    import sat_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 4;

    logic clk;
    logic rst_n;

    sat_add_arbiter_if #(.NREQ(N), .WIDTH(W)) bus ();

    sat_add_arbiter #(.NREQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    int m_last;
    int m_valid;
    int m_sum;
    int m_id;
    int m_sat;
    int exp_gnt;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last  = N - 1;
        m_valid = 0;
        m_sum   = 0;
        m_id    = 0;
        m_sat   = 0;
    endtask

    // Returns the winning requester index, or -1 when there is no grant.
    function automatic int model_pick(input logic [N-1:0] r, input logic rdy);
        if (m_valid != 0 && !rdy) return -1;
        for (int k = 1; k <= N; k++) begin
            if (r[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, int'(bus.res_valid), m_valid);
        check({tag, ".sum"},   int'(bus.res_sum),   m_sum);
        check({tag, ".id"},    int'(bus.res_id),    m_id);
        check({tag, ".sat"},   int'(bus.res_sat),   m_sat);
    endtask

    // Performs one clock cycle. Call it just after a falling edge.
    task automatic do_cycle(input logic [N-1:0] r, input logic [N*W-1:0] a,
                            input logic [N*W-1:0] b, input logic rdy);
        int w;
        int s;
        bus.req       = r;
        bus.a_in      = a;
        bus.b_in      = b;
        bus.res_ready = rdy;
        #1;
        w       = model_pick(r, rdy);
        exp_gnt = (w >= 0) ? (1 << w) : 0;
        check("gnt", int'(bus.gnt), exp_gnt);
        @(posedge clk);
        if (w >= 0) begin
            s       = int'(a[w*W +: W]) + int'(b[w*W +: W]);
            m_valid = 1;
            m_last  = w;
            m_id    = w;
            m_sat   = (s > int'(SAT_MAX)) ? 1 : 0;
            m_sum   = (s > int'(SAT_MAX)) ? int'(SAT_MAX) : s;
        end else if (rdy) begin
            m_valid = 0;
        end
        #1;
        check_outputs("out");
        $display("cyc req=%b rdy=%0d gnt=%b valid=%0d sum=%0d id=%0d sat=%0d",
                 r, rdy, bus.gnt, bus.res_valid, bus.res_sum, bus.res_id, bus.res_sat);
        @(negedge clk);
    endtask

    task automatic apply_reset(input int cycles);
        rst_n    = 1'b0;
        bus.req  = '1;
        model_reset();
        repeat (cycles) @(posedge clk);
        #1;
        check("rst.gnt", int'(bus.gnt), 0);
        check_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [N*W-1:0] lane(input int idx, input int v);
        logic [N*W-1:0] x;
        x = '0;
        x[idx*W +: W] = W'(v);
        return x;
    endfunction

    initial begin
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.res_ready = 1'b1;
        model_reset();

        apply_reset(3);

        // A single request with no saturation.
        do_cycle(4'b0100, lane(2, 9), lane(2, 3), 1'b1);
        check("single.gnt", exp_gnt, 4);
        check("single.sum", int'(bus.res_sum), 12);
        check("single.id",  int'(bus.res_id), 2);

        // Saturation boundaries on requester 0.
        do_cycle(4'b0001, lane(0, 15), lane(0, 1), 1'b1);
        check("sat1.sum", int'(bus.res_sum), 15);
        check("sat1.sat", int'(bus.res_sat), 1);
        do_cycle(4'b0001, lane(0, 8), lane(0, 8), 1'b1);
        check("sat2.sat", int'(bus.res_sat), 1);
        do_cycle(4'b0001, lane(0, 7), lane(0, 8), 1'b1);
        check("sat3.sum", int'(bus.res_sum), 15);
        check("sat3.sat", int'(bus.res_sat), 0);

        // Drain, then check fairness from a fresh reset.
        do_cycle(4'b0000, '0, '0, 1'b1);
        apply_reset(2);
        for (int i = 0; i < 8; i++) begin
            do_cycle(4'b1111, {$urandom}, {$urandom}, 1'b1);
            check("fair.gnt", exp_gnt, 1 << (i % 4));
            check("fair.id", int'(bus.res_id), i % 4);
        end

        // Backpressure: hold FULL, then release.
        do_cycle(4'b0011, {$urandom}, {$urandom}, 1'b1);
        for (int i = 0; i < 4; i++) begin
            do_cycle(4'b0011, {$urandom}, {$urandom}, 1'b0);
            check("bp.gnt", exp_gnt, 0);
        end
        do_cycle(4'b0011, {$urandom}, {$urandom}, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            do_cycle(N'($urandom_range(0, 15)), {$urandom}, {$urandom},
                     ($urandom_range(0, 3) != 0));
        end

        // Reset asserted between edges while FULL.
        do_cycle(4'b1111, {$urandom}, {$urandom}, 1'b1);
        bus.req       = 4'b1010;
        bus.res_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst.gnt", int'(bus.gnt), 0);
        check_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        do_cycle(4'b1010, {$urandom}, {$urandom}, 1'b1);
        check("midrst.first", exp_gnt, 2);
        check("midrst.id", int'(bus.res_id), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Safety net in case a wait ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule
